mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM port between instruction fetch (IF) and the
//  load/store stage (MEM). Sequences each request as 1/2/4 byte transfers and
//  assembles or splits words little-endian. Drives stallreq_o to ctrl so the
//  pipeline holds while any access is pending.
// PARAMETERS
//  RAM_LAT  1  RAM read latency in cycles (1 or 2); ram_din_i valid RAM_LAT cycles after ram_a_o
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, synchronous, active-low
//  if_req_i     in   1   IF word-read request; held until if_done_o or if_flush_i
//  if_addr_i    in   32  IF fetch address (pc)
//  if_flush_i   in   1   branch taken: cancel pending/active IF read
//  if_data_o    out  32  fetched instruction, valid with if_done_o
//  if_done_o    out  1   one-cycle completion pulse for IF
//  mem_req_i    in   1   MEM request; held until mem_done_o
//  mem_we_i     in   1   1 = store, 0 = load
//  mem_addr_i   in   32  byte address
//  mem_len_i    in   2   0 = byte, 1 = half, 2 = word (3 treated as word)
//  mem_wdata_i  in   32  store data, low bytes used
//  mem_rdata_o  out  32  load data, zero-extended raw bytes, valid with mem_done_o
//  mem_done_o   out  1   one-cycle completion pulse for MEM
//  ram_din_i    in   8   RAM read data
//  ram_dout_o   out  8   RAM write data
//  ram_a_o      out  32  RAM byte address
//  ram_wr_o     out  1   RAM write strobe
//  stallreq_o   out  1   (if_req_i & ~if_done_o) | (mem_req_i & ~mem_done_o), combinational
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE, all registered outputs 0, byte counter 0,
//    last_grant = MEM. Reset mid-transfer aborts it; no done pulse; ram_wr_o 0 next cycle.
//  - States: IDLE -> XFER -> WAIT -> DONE -> IDLE. WAIT skipped for writes.
//  - IDLE at cycle T: sample requests; grant latched with addr/len/we/wdata. Both
//    requesting: MEM wins. IF request with if_flush_i high is not granted.
//  - XFER: N bytes (IF always 4), cycles T+1..T+N, ram_a_o = base+k, k=0..N-1;
//    address add wraps mod 2^32. Store: ram_wr_o=1, ram_dout_o = wdata[8k+7:8k].
//  - Load: byte k captured RAM_LAT cycles after its address into data[8k+7:8k];
//    WAIT holds until last byte captured. Unused upper bytes read as 0.
//  - DONE: done pulse + data for granted requester. Store done at T+N+1; load done
//    at T+N+RAM_LAT+1 (word load, RAM_LAT=1: T+6). Next cycle IDLE, new grant earliest
//    one cycle after done; requester drops/changes req on the edge ending done cycle.
//  - if_flush_i during IF XFER/WAIT/DONE: abort, IDLE next cycle, if_done_o never pulses,
//    late RAM bytes discarded. Flush has no effect on MEM grants (stores never aborted).
//  - Outside XFER: ram_a_o 0, ram_wr_o 0, ram_dout_o 0. if_data_o/mem_rdata_o hold last value.
//  - Requester changing addr mid-grant has no effect (latched copy used).
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin on simultaneous requests; grant goes to requester
//  not in last_grant (reset value MEM, so IF first after reset). Single requester
//  always granted. Undefined: fixed MEM-over-IF priority, last_grant unused.
// TESTING
//  1. RAM[0x1000..3]=13 57 9B DF, IF req 0x1000 at T -> if_done_o at T+6, if_data_o=0xDF9B5713.
//  2. MEM SB 0x2003 data 0x...A5 -> ram_wr_o=1 only at T+1, ram_a_o=0x2003, dout=A5, done T+2.
//  3. IF+MEM LH 0x3000 (RAM 34 12) same cycle -> mem_rdata_o=0x00001234 first, IF granted after.
//  4. IF word read, flush at byte 2 -> no if_done_o, IDLE next cycle, ram_wr_o stays 0.
//  5. rst=0 during SW XFER byte 1 -> next edge ram_wr_o=0, ram_a_o=0, no mem_done_o.
//  6. MEM_ARB_RR_EN, both reqs reissued after every done -> grants IF,MEM,IF,MEM; undefined: MEM repeatedly.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IF and MEM stages, the shared byte-wide RAM
// port and the pipeline stall line. The arbiter connects to the slave modport.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_data_o;
  logic        if_done_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;

  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;

  logic        stallreq_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_data_o, if_done_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
    output mem_rdata_o, mem_done_o,
    input  ram_din_i,
    output ram_dout_o, ram_a_o, ram_wr_o,
    output stallreq_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_data_o, if_done_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
    input  mem_rdata_o, mem_done_o,
    output ram_din_i,
    input  ram_dout_o, ram_a_o, ram_wr_o,
    input  stallreq_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter for IF and MEM; splits/assembles 1/2/4-byte transfers
// little-endian. Define MEM_ARB_RR_EN for round-robin arbitration (default: MEM wins).
module mem_arbiter #(
  parameter int RAM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic {
    G_IF,
    G_MEM
  } grant_t;

  state_t             r_state;
  state_t             w_state_next;
  grant_t             r_grant;
  grant_t             w_grant_sel;
  logic               w_take;
  logic               w_if_ok;
  logic               w_abort;
  logic               w_issue;
  logic               w_cap;
  logic               w_if_done;
  logic               w_mem_done;

  logic [31:0]        r_addr;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [1:0]         r_last;
  logic [1:0]         r_cnt;
  logic [1:0]         r_cap_idx;
  logic [RAM_LAT-1:0] r_pipe;
  logic [31:0]        r_buf;
  logic [31:0]        r_if_hold;
  logic [31:0]        r_mem_hold;
  logic [1:0]         w_len_last;

`ifdef MEM_ARB_RR_EN
  grant_t             r_last_grant;
`endif

  // A request arriving together with a flush is a fetch the branch already killed.
  assign w_if_ok = bus.if_req_i & ~bus.if_flush_i;

  always_comb begin
    w_take      = bus.mem_req_i | w_if_ok;
    w_grant_sel = bus.mem_req_i ? G_MEM : G_IF;
`ifdef MEM_ARB_RR_EN
    if (bus.mem_req_i && w_if_ok) begin
      w_grant_sel = (r_last_grant == G_MEM) ? G_IF : G_MEM;
    end
`endif
  end

  always_comb begin
    unique case (bus.mem_len_i)
      2'd0:    w_len_last = 2'd0;
      2'd1:    w_len_last = 2'd1;
      default: w_len_last = 2'd3;
    endcase
  end

  assign w_abort = (r_grant == G_IF) && bus.if_flush_i && (r_state != S_IDLE);
  assign w_issue = (r_state == S_XFER) && !r_we && !w_abort;
  // The oldest pipe stage marks a read byte whose data is on ram_din_i this cycle.
  assign w_cap   = r_pipe[RAM_LAT-1];

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_take) w_state_next = S_XFER;
      end
      S_XFER: begin
        if (w_abort)               w_state_next = S_IDLE;
        else if (r_cnt == r_last)  w_state_next = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (w_abort)                           w_state_next = S_IDLE;
        else if (w_cap && r_cap_idx == r_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ram_a_o    = '0;
    bus.ram_wr_o   = 1'b0;
    bus.ram_dout_o = '0;
    if (r_state == S_XFER) begin
      bus.ram_a_o = r_addr + {30'd0, r_cnt};
      if (r_we) begin
        bus.ram_wr_o   = 1'b1;
        bus.ram_dout_o = r_wdata[{r_cnt, 3'b000} +: 8];
      end
    end
  end

  assign w_if_done  = (r_state == S_DONE) && (r_grant == G_IF) && !bus.if_flush_i;
  assign w_mem_done = (r_state == S_DONE) && (r_grant == G_MEM);

  assign bus.if_done_o   = w_if_done;
  assign bus.mem_done_o  = w_mem_done;
  assign bus.if_data_o   = w_if_done  ? r_buf : r_if_hold;
  assign bus.mem_rdata_o = w_mem_done ? r_buf : r_mem_hold;

  assign bus.stallreq_o = (bus.if_req_i & ~w_if_done) | (bus.mem_req_i & ~w_mem_done);

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_grant    <= G_MEM;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_last     <= '0;
      r_cnt      <= '0;
      r_cap_idx  <= '0;
      r_pipe     <= '0;
      r_buf      <= '0;
      r_if_hold  <= '0;
      r_mem_hold <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_grant <= G_MEM;
`endif
    end else begin
      r_state <= w_state_next;

      // Flushing the pipe on abort and in IDLE drops bytes still in flight.
      if (r_state == S_IDLE || w_abort) r_pipe <= '0;
      else                              r_pipe <= RAM_LAT'({r_pipe, w_issue});

      if (r_state == S_IDLE) begin
        if (w_take) begin
          r_grant   <= w_grant_sel;
          r_cnt     <= '0;
          r_cap_idx <= '0;
          r_buf     <= '0;
`ifdef MEM_ARB_RR_EN
          r_last_grant <= w_grant_sel;
`endif
          if (w_grant_sel == G_MEM) begin
            r_addr  <= bus.mem_addr_i;
            r_we    <= bus.mem_we_i;
            r_wdata <= bus.mem_wdata_i;
            r_last  <= w_len_last;
          end else begin
            r_addr  <= bus.if_addr_i;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_last  <= 2'd3;
          end
        end
      end else begin
        if (r_state == S_XFER) r_cnt <= r_cnt + 2'd1;
        if (w_cap) begin
          r_buf[{r_cap_idx, 3'b000} +: 8] <= bus.ram_din_i;
          r_cap_idx                       <= r_cap_idx + 2'd1;
        end
      end

      if (w_if_done)  r_if_hold  <= r_buf;
      if (w_mem_done) r_mem_hold <= r_buf;
    end
  end

endmodule
